// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - value/load/dot inputs and scanned display outputs of the seven-segment driver

interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] i_value;
  logic                    i_load;
  logic [NUM_DIGITS-1:0]   i_dot;
  logic [0:6]              o_segment_enable;
  logic [0:NUM_DIGITS-1]   o_display_enable;
  logic                    o_dot_enable;
  logic                    o_frame_start;

  modport master (
    output i_value, i_load, i_dot,
    input  o_segment_enable, o_display_enable, o_dot_enable, o_frame_start
  );

  modport slave (
    input  i_value, i_load, i_dot,
    output o_segment_enable, o_display_enable, o_dot_enable, o_frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed hex seven-segment scanner with double-buffered value
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic         clk,
  input  logic         i_reset,
  seg7_scan_if.slave   bus
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);

  function automatic logic [0:6] glyph(input logic [3:0] nib);
    logic [0:6] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  logic [PRE_W-1:0]      prescaler_q, prescaler_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [0:6]            seg_q, seg_d;
  logic [0:NUM_DIGITS-1] de_q, de_d;
  logic                  dot_q, dot_d;
  logic                  fs_q, fs_d;

  logic       tick;
  logic       boundary;
  logic [3:0] nibble;
  logic       dot_req;
  logic       slot_blank;
  logic       lz_blank;
  logic       zero_run;

  always_comb begin
    tick     = (prescaler_q == PRE_LAST);
    boundary = tick && (idx_q == IDX_LAST);

    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Transfer reads the old pending word, so a load landing on the boundary stays pending
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    disp_d          = disp_q;
    if (boundary && pending_valid_q) begin
      disp_d          = pending_q;
      pending_valid_d = 1'b0;
    end
    if (bus.i_load) begin
      pending_d       = bus.i_value;
      pending_valid_d = 1'b1;
    end

    nibble  = 4'h0;
    dot_req = 1'b0;
    de_d    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibble  = disp_q[4*k +: 4];
        dot_req = bus.i_dot[k];
        de_d[k] = 1'b0;
      end
    end

    slot_blank = (BLANK_CYCLES > 0) && (prescaler_q < BLANK_END);

    lz_blank = 1'b0;
    zero_run = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a slot blanks while everything at or above it is zero
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && (disp_q[4*k +: 4] == 4'h0);
      if ((idx_q == IDX_W'(k)) && zero_run) begin
        lz_blank = 1'b1;
      end
    end
`else
    zero_run = 1'b0;
`endif

    if (slot_blank || lz_blank || zero_run && 1'b0) begin
      seg_d = '1;
      de_d  = '1;
      dot_d = 1'b1;
    end else begin
      seg_d = glyph(nibble);
      dot_d = ~dot_req;
    end

    fs_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      prescaler_q     <= '0;
      idx_q           <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      disp_q          <= '0;
      seg_q           <= '1;
      de_q            <= '1;
      dot_q           <= 1'b1;
      fs_q            <= 1'b0;
    end else begin
      prescaler_q     <= prescaler_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      disp_q          <= disp_d;
      seg_q           <= seg_d;
      de_q            <= de_d;
      dot_q           <= dot_d;
      fs_q            <= fs_d;
    end
  end

  assign bus.o_segment_enable = seg_q;
  assign bus.o_display_enable = de_q;
  assign bus.o_dot_enable     = dot_q;
  assign bus.o_frame_start    = fs_q;

endmodule
